// File: rtl/hazard_unit.sv
// Load-use hazard detection, stall sequencing and branch-flush control for the five-stage core.
// Optional build macro HAZARD_UNIT_STATS_EN adds saturating stall/flush event counters.
module hazard_unit #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int REG_ADDR_W        = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  branch_taken,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  control_mux_sel,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush
`ifdef HAZARD_UNIT_STATS_EN
   ,
   output logic [31:0]           stall_count,
   output logic [31:0]           flush_count
`endif
);

   typedef enum logic {RUN, STALL} state_t;

   localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

   state_t     st_reg, st_next;
   logic [1:0] cnt_reg, cnt_next;
   logic       hz;

   // x0 is hardwired to zero, so a load targeting it can never create a dependency.
   assign hz = ex_mem_read && (ex_rd != '0) &&
               ((id_uses_rs1 && (ex_rd == id_rs1)) || (id_uses_rs2 && (ex_rd == id_rs2)));

   always_comb begin
      st_next         = st_reg;
      cnt_next        = cnt_reg;
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      control_mux_sel = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem_flush    = 1'b0;
      if (!rst_n) begin
         // Front end frozen with bubbles for as long as the core is held in reset.
         pc_write        = 1'b0;
         if_id_write     = 1'b0;
         control_mux_sel = 1'b1;
      end else if (branch_taken) begin
         // The resolving branch is older than anything stalled behind it, so flush wins.
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         st_next      = RUN;
         cnt_next     = 2'd0;
      end else if (st_reg == STALL) begin
         pc_write        = 1'b0;
         if_id_write     = 1'b0;
         control_mux_sel = 1'b1;
         cnt_next        = cnt_reg - 2'd1;
         if (cnt_reg == 2'd1) begin
            st_next = RUN;
         end
      end else if (hz) begin
         pc_write        = 1'b0;
         if_id_write     = 1'b0;
         control_mux_sel = 1'b1;
         if (LOAD_STALL_CYCLES > 1) begin
            st_next  = STALL;
            cnt_next = STALL_INIT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_reg  <= RUN;
         cnt_reg <= 2'd0;
      end else begin
         st_reg  <= st_next;
         cnt_reg <= cnt_next;
      end
   end

`ifdef HAZARD_UNIT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (control_mux_sel && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
         end
         if (if_id_flush && (flush_count != '1)) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a 1-cycle and a 3-cycle instance share the same stimulus.
// Directed vectors push hand-computed expectations; a negedge monitor pops and compares.
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;

   logic pw1, iw1, cm1, fa1, fb1, fc1;
   logic pw3, iw3, cm3, fa3, fb3, fc3;
`ifdef HAZARD_UNIT_STATS_EN
   logic [31:0] sc1, fl1, sc3, fl3;
`endif

   always #5 clk = ~clk;

   hazard_unit #(.LOAD_STALL_CYCLES(1), .REG_ADDR_W(5)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
      .pc_write(pw1), .if_id_write(iw1), .control_mux_sel(cm1),
      .if_id_flush(fa1), .id_ex_flush(fb1), .ex_mem_flush(fc1)
`ifdef HAZARD_UNIT_STATS_EN
      , .stall_count(sc1), .flush_count(fl1)
`endif
   );

   hazard_unit #(.LOAD_STALL_CYCLES(3), .REG_ADDR_W(5)) dut3 (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
      .pc_write(pw3), .if_id_write(iw3), .control_mux_sel(cm3),
      .if_id_flush(fa3), .id_ex_flush(fb3), .ex_mem_flush(fc3)
`ifdef HAZARD_UNIT_STATS_EN
      , .stall_count(sc3), .flush_count(fl3)
`endif
   );

   // {pc_write, if_id_write, control_mux_sel, if_id_flush, id_ex_flush, ex_mem_flush}
   localparam logic [5:0] NRM = 6'b110000;
   localparam logic [5:0] STL = 6'b001000;
   localparam logic [5:0] FLS = 6'b110111;

   typedef struct {
      logic [5:0] e1;
      logic [5:0] e3;
      bit         chk_zero;
      int         id;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   txn   = 0;

   task automatic vec(input logic r, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic br,
                      input logic [5:0] e1, input logic [5:0] e3, input bit cz);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n        = r;
      ex_mem_read  = mr;
      ex_rd        = rd;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_uses_rs1  = u1;
      id_uses_rs2  = u2;
      branch_taken = br;
      e.e1 = e1;
      e.e3 = e3;
      e.chk_zero = cz;
      e.id = txn;
      txn++;
      sb_q.push_back(e);
   endtask

   task automatic idle(input logic [5:0] e1, input logic [5:0] e3);
      vec(1, 0, 0, 0, 0, 0, 0, 0, e1, e3, 0);
   endtask

   // Monitor: every cycle is an output; compare at the falling edge.
   always @(negedge clk) begin
      exp_t       e;
      logic [5:0] o1, o3;
      if (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         o1 = {pw1, iw1, cm1, fa1, fb1, fc1};
         o3 = {pw3, iw3, cm3, fa3, fb3, fc3};
         $display("txn %0d: rst_n=%b dut1=%b dut3=%b", e.id, rst_n, o1, o3);
         total++;
         if (o1 !== e.e1) begin
            bad++;
            $display("FAIL txn%0d_dut1 got=%b want=%b", e.id, o1, e.e1);
         end
         total++;
         if (o3 !== e.e3) begin
            bad++;
            $display("FAIL txn%0d_dut3 got=%b want=%b", e.id, o3, e.e3);
         end
`ifdef HAZARD_UNIT_STATS_EN
         if (e.chk_zero) begin
            total++;
            if ((sc1 !== 32'd0) || (sc3 !== 32'd0)) begin
               bad++;
               $display("FAIL txn%0d_stall_count got=%0d/%0d want=0/0", e.id, sc1, sc3);
            end
         end
`endif
      end
   end

   initial begin
      // Reset held: frozen with bubbles.
      vec(0, 0, 0, 0, 0, 0, 0, 0, STL, STL, 0);
      vec(0, 1, 5, 5, 0, 1, 0, 0, STL, STL, 0);
      idle(NRM, NRM);
      // rs1 load-use: 1 bubble vs 3 bubbles.
      vec(1, 1, 5, 5, 0, 1, 0, 0, STL, STL, 0);
      idle(NRM, STL);
      idle(NRM, STL);
      idle(NRM, NRM);
      // x0 never hazards; rs2 match ignored when rs2 unused.
      vec(1, 1, 0, 0, 0, 1, 1, 0, NRM, NRM, 0);
      vec(1, 1, 7, 3, 7, 1, 0, 0, NRM, NRM, 0);
      // rs2 hazard, held for several cycles.
      vec(1, 1, 7, 3, 7, 1, 1, 0, STL, STL, 0);
      idle(NRM, STL);
      idle(NRM, STL);
      idle(NRM, NRM);
      // Branch in the 2nd stall cycle aborts the stall.
      vec(1, 1, 9, 9, 0, 1, 0, 0, STL, STL, 0);
      vec(1, 0, 0, 0, 0, 0, 0, 1, FLS, FLS, 0);
      idle(NRM, NRM);
      // Hazard and branch together: flush wins, no stall follows.
      vec(1, 1, 4, 0, 4, 0, 1, 1, FLS, FLS, 0);
      idle(NRM, NRM);
      // Back-to-back: new hazard in the cycle dut3 returns to RUN.
      vec(1, 1, 5, 5, 0, 1, 0, 0, STL, STL, 0);
      idle(NRM, STL);
      idle(NRM, STL);
      vec(1, 1, 6, 6, 6, 1, 1, 0, STL, STL, 0);
      idle(NRM, STL);
      idle(NRM, STL);
      idle(NRM, NRM);
      // Reset mid-stall: immediate bubble outputs, counters cleared, clean RUN after.
      vec(1, 1, 5, 5, 0, 1, 0, 0, STL, STL, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, STL, STL, 1);
      idle(NRM, NRM);
      idle(NRM, NRM);
      repeat (3) @(posedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage core. It detects load-use hazards between the ID and EX stages and produces the select for the stall control mux, which zeroes the ID/EX control bits. It also gates the PC and the IF/ID register and sequences branch flushes. A small FSM extends a load-use stall to a configurable number of cycles, so the unit works with slower data memories.

## Interface
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1–3.
- REG_ADDR_W, 5: register index width.

- clk, input, 1: core clock; all state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- id_rs1, input, REG_ADDR_W: rs1 of the instruction in ID.
- id_rs2, input, REG_ADDR_W: rs2 of the instruction in ID.
- id_uses_rs1, input, 1: the ID instruction reads rs1.
- id_uses_rs2, input, 1: the ID instruction reads rs2.
- ex_rd, input, REG_ADDR_W: destination of the instruction in EX.
- ex_mem_read, input, 1: the EX instruction is a load.
- branch_taken, input, 1: a branch resolved taken in MEM this cycle.
- pc_write, output, 1: PC update enable.
- if_id_write, output, 1: IF/ID register write enable.
- control_mux_sel, output, 1: 1 = stall control mux outputs all-zero control bits (bubble).
- if_id_flush, output, 1: clear IF/ID to a NOP at the next edge.
- id_ex_flush, output, 1: clear ID/EX at the next edge.
- ex_mem_flush, output, 1: clear EX/MEM control at the next edge.

## Operation
- Hazard term: hz = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
- State: st ∈ {RUN, STALL} and a 2-bit down-counter cnt.

In RUN:
- branch_taken = 1:
  - Drives if_id_flush = id_ex_flush = ex_mem_flush = 1, pc_write = 1, if_id_write = 1, control_mux_sel = 0.
  - hz is ignored.
  - Next state RUN.
- Otherwise hz = 1:
  - Drives pc_write = 0, if_id_write = 0, control_mux_sel = 1.
  - If LOAD_STALL_CYCLES > 1: next state STALL, cnt ← LOAD_STALL_CYCLES−1. Else stay in RUN.
- Otherwise: pc_write = if_id_write = 1, all other outputs 0.

In STALL:
- Outputs are the same as a RUN hazard cycle, whether or not hz holds (the load has left EX).
- Each cycle cnt decrements. When cnt == 1, the next state is RUN.
- branch_taken = 1 in STALL:
  - The flush wins: the branch is older than the stalled instruction.
  - Flush outputs as in RUN, with control_mux_sel = 0.
  - Next state RUN, cnt ← 0.

General rules:
- Flush and stall are never asserted together.
- x0 never causes a hazard.

## Timing
- All outputs are combinational from the inputs and the registered state, valid in the same cycle as the inputs. Detection has zero-cycle latency.
- One hazard stalls for exactly LOAD_STALL_CYCLES consecutive cycles. pc_write returns to 1 in the cycle after the last stall cycle.
- Asynchronous reset (rst_n = 0) immediately forces:
  - st = RUN, cnt = 0.
  - pc_write = 0, if_id_write = 0, control_mux_sel = 1.
  - if_id_flush = id_ex_flush = ex_mem_flush = 0.
- This holds the front end frozen with bubbles while the core is in reset.
- After deassertion, normal operation starts at the first rising edge.
- Reset asserted mid-STALL aborts the stall with no residual bubbles.
- A new hz in the cycle the FSM returns to RUN starts a fresh stall sequence. Back-to-back load-use pairs are legal.

## Configuration
- HAZARD_UNIT_STATS_EN defined:
  - Adds output stall_count (32-bit), which increments in every cycle with control_mux_sel = 1 and rst_n = 1.
  - Adds output flush_count (32-bit), which increments in every cycle with if_id_flush = 1.
  - Both counters saturate at 0xFFFFFFFF, reset asynchronously to 0, and are registered (they reflect the previous cycle).
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- LOAD_STALL_CYCLES = 1; ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 for one cycle:
  - That cycle has pc_write = 0, if_id_write = 0, control_mux_sel = 1.
  - The next cycle (ex_mem_read = 0) has pc_write = 1, control_mux_sel = 0.
- Same hazard with ex_rd = 0, or with id_uses_rs2 = 0 and a match only on rs2 -> no stall: pc_write = 1, control_mux_sel = 0.
- LOAD_STALL_CYCLES = 3, one hazard cycle -> exactly 3 consecutive cycles with control_mux_sel = 1, then pc_write = 1.
- LOAD_STALL_CYCLES = 3; hazard, then branch_taken = 1 in the 2nd stall cycle:
  - That cycle has all three flushes = 1, control_mux_sel = 0, pc_write = 1.
  - The next cycle is in RUN with no stall.
- Hazard and branch_taken in the same RUN cycle -> flushes = 1, control_mux_sel = 0, pc_write = 1, FSM stays in RUN.
- rst_n pulled low during STALL -> outputs go immediately to pc_write = 0, control_mux_sel = 1, flushes 0. After release, a clean RUN. With HAZARD_UNIT_STATS_EN, stall_count = 0 after reset.
